// File: rtl/apple2_ps2_keyboard_if.sv
// Keyboard-side bus of the Apple II $C000/$C010 interface: PS/2 lines in, latched key out.
// The any_key_down signal exists only when APPLE2_ANYKEY_EN is defined.
interface apple2_ps2_keyboard_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       read_key;
  logic [7:0] keyboard_data_l;
  logic       frame_error;
  // Receiver FSM state for debug: 0 IDLE, 1 DATA, 2 PARITY, 3 STOP.
  logic [1:0] rx_state;
`ifdef APPLE2_ANYKEY_EN
  logic       any_key_down;

  modport slave  (input  ps2_clk, ps2_data, read_key,
                  output keyboard_data_l, frame_error, rx_state, any_key_down);
  modport master (output ps2_clk, ps2_data, read_key,
                  input  keyboard_data_l, frame_error, rx_state, any_key_down);
`else
  modport slave  (input  ps2_clk, ps2_data, read_key,
                  output keyboard_data_l, frame_error, rx_state);
  modport master (output ps2_clk, ps2_data, read_key,
                  input  keyboard_data_l, frame_error, rx_state);
`endif
endinterface

// File: rtl/apple2_ps2_keyboard.sv
// PS/2 set-2 receiver and decoder producing the Apple II $C000 key latch {strobe, ascii}.
// Optional held-key counter and any_key_down output are enabled with APPLE2_ANYKEY_EN.
module apple2_ps2_keyboard #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int TIMEOUT_US  = 200,
  parameter int FILTER_LEN  = 8
) (
  input logic                  Clock_50Mhz,
  input logic                  RESET_N,
  apple2_ps2_keyboard_if.slave kbd
);

  localparam int TIMEOUT_CYC = CLK_FREQ_HZ / 1000000 * TIMEOUT_US;
  localparam int TO_W        = $clog2(TIMEOUT_CYC + 1);
  localparam int FL_W        = $clog2(FILTER_LEN + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  logic [1:0]      clk_sync;
  logic [1:0]      data_sync;
  logic            clk_filt;
  logic [FL_W-1:0] filt_cnt;
  logic            fall;

  rx_state_t       state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_reg;
  logic            parity_bit;
  logic [TO_W-1:0] to_cnt;
  logic            rx_valid;
  logic            frame_err_q;

  logic [7:0]      key_q;
  logic            shift_q;
  logic            ctrl_q;
  logic            ext_q;
  logic            brk_q;
  logic            map_hit;
  logic [6:0]      map_ascii;

  always_ff @(posedge Clock_50Mhz or negedge RESET_N) begin
    if (!RESET_N) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], kbd.ps2_clk};
      data_sync <= {data_sync[0], kbd.ps2_data};
    end
  end

  // The filtered level flips only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge Clock_50Mhz or negedge RESET_N) begin
    if (!RESET_N) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FL_W'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        filt_cnt <= '0;
        fall     <= clk_filt;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock_50Mhz or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      parity_bit  <= 1'b0;
      to_cnt      <= '0;
      rx_valid    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_err_q <= 1'b0;
      if (fall) begin
        case (state)
          IDLE: begin
            if (!data_sync[1]) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift_reg <= {data_sync[1], shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parity_bit <= data_sync[1];
            state      <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (data_sync[1] && (^shift_reg ^ parity_bit)) rx_valid <= 1'b1;
            else frame_err_q <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
      // Gap watchdog between falls; state only changes here when no fall is present.
      if (state != IDLE && !fall) begin
        if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
          state       <= IDLE;
          frame_err_q <= 1'b1;
          to_cnt      <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

  function automatic logic [7:0] key_map(input logic [7:0] code, input logic ext,
                                         input logic shift, input logic ctrl);
    logic [6:0] a;
    logic       hit;
    a   = '0;
    hit = 1'b1;
    if (ext) begin
      case (code)
        8'h6B:   a = 7'h08;
        8'h74:   a = 7'h15;
        default: hit = 1'b0;
      endcase
    end else begin
      case (code)
        8'h1C: a = 7'h41;  8'h32: a = 7'h42;  8'h21: a = 7'h43;  8'h23: a = 7'h44;
        8'h24: a = 7'h45;  8'h2B: a = 7'h46;  8'h34: a = 7'h47;  8'h33: a = 7'h48;
        8'h43: a = 7'h49;  8'h3B: a = 7'h4A;  8'h42: a = 7'h4B;  8'h4B: a = 7'h4C;
        8'h3A: a = 7'h4D;  8'h31: a = 7'h4E;  8'h44: a = 7'h4F;  8'h4D: a = 7'h50;
        8'h15: a = 7'h51;  8'h2D: a = 7'h52;  8'h1B: a = 7'h53;  8'h2C: a = 7'h54;
        8'h3C: a = 7'h55;  8'h2A: a = 7'h56;  8'h1D: a = 7'h57;  8'h22: a = 7'h58;
        8'h35: a = 7'h59;  8'h1A: a = 7'h5A;
        8'h16: a = shift ? 7'h21 : 7'h31;
        8'h1E: a = shift ? 7'h40 : 7'h32;
        8'h26: a = shift ? 7'h23 : 7'h33;
        8'h25: a = shift ? 7'h24 : 7'h34;
        8'h2E: a = shift ? 7'h25 : 7'h35;
        8'h36: a = shift ? 7'h5E : 7'h36;
        8'h3D: a = shift ? 7'h26 : 7'h37;
        8'h3E: a = shift ? 7'h2A : 7'h38;
        8'h46: a = shift ? 7'h28 : 7'h39;
        8'h45: a = shift ? 7'h29 : 7'h30;
        8'h41: a = shift ? 7'h3C : 7'h2C;
        8'h49: a = shift ? 7'h3E : 7'h2E;
        8'h4A: a = shift ? 7'h3F : 7'h2F;
        8'h4C: a = shift ? 7'h3A : 7'h3B;
        8'h52: a = shift ? 7'h22 : 7'h27;
        8'h4E: a = shift ? 7'h5F : 7'h2D;
        8'h55: a = shift ? 7'h2B : 7'h3D;
        8'h29: a = 7'h20;
        8'h5A: a = 7'h0D;
        8'h66: a = 7'h08;
        8'h76: a = 7'h1B;
        default: hit = 1'b0;
      endcase
      // Only letters live in 41..5A in this map, so ctrl folds nothing else.
      if (ctrl && a >= 7'h41 && a <= 7'h5A) a = a & 7'h1F;
    end
    return {hit, a};
  endfunction

  assign {map_hit, map_ascii} = key_map(shift_reg, ext_q, shift_q, ctrl_q);

`ifdef APPLE2_ANYKEY_EN
  logic [2:0] held_cnt;
  assign kbd.any_key_down = (held_cnt != 3'd0);
`endif

  // read_key is applied first so a key landing in the same cycle keeps its strobe.
  always_ff @(posedge Clock_50Mhz or negedge RESET_N) begin
    if (!RESET_N) begin
      key_q   <= 8'h00;
      shift_q <= 1'b0;
      ctrl_q  <= 1'b0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
`ifdef APPLE2_ANYKEY_EN
      held_cnt <= 3'd0;
`endif
    end else begin
      if (kbd.read_key) key_q[7] <= 1'b0;
      if (rx_valid) begin
        if (shift_reg == 8'hE0) begin
          ext_q <= 1'b1;
        end else if (shift_reg == 8'hF0) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
          if (shift_reg == 8'h12 || shift_reg == 8'h59) begin
            shift_q <= ~brk_q;
          end else if (shift_reg == 8'h14) begin
            ctrl_q <= ~brk_q;
          end else if (map_hit) begin
            if (!brk_q) key_q <= {1'b1, map_ascii};
`ifdef APPLE2_ANYKEY_EN
            if (!brk_q) begin
              if (held_cnt != 3'd7) held_cnt <= held_cnt + 3'd1;
            end else if (held_cnt != 3'd0) begin
              held_cnt <= held_cnt - 3'd1;
            end
`endif
          end
        end
      end
    end
  end

  assign kbd.keyboard_data_l = key_q;
  assign kbd.frame_error     = frame_err_q;
  assign kbd.rx_state        = state;

endmodule
